// File: rtl/mux81_rr_sched.sv
// -----------------------------------------------------------------------------
// mux81_rr_sched
//   Round-robin scheduler in front of an 8:1 one-bit multiplexer. It picks one
//   requester at a time, drives the mux select, and registers the selected data
//   bit with a valid flag. Each grant is limited to MAX_HOLD consecutive cycles.
//
// Request/grant protocol: req[k] is a level. Requester k holds it high for as
// long as it wants the mux. gnt[k] is registered and one-hot. A grant lasts
// while req[k] stays high and the burst limit has not been reached. Dropping
// req[k] releases the grant at the next edge.
//
// Parameters
//   MAX_HOLD   maximum consecutive grant cycles per requester (1..15)
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   req[7:0]   request vector, bit k = requester k (owns mux input k)
//   din[7:0]   mux data inputs {i7..i0}
//   gnt[7:0]   one-hot grant, zero when idle
//   s[2:0]     mux select = index of the granted requester (holds while idle)
//   y          registered mux output
//   y_valid    y was sampled under a valid grant
//   busy       grant active (decoded from the registered FSM state)
// -----------------------------------------------------------------------------
module mux81_rr_sched #(
   parameter int MAX_HOLD = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   input  logic [7:0] din,
   output logic [7:0] gnt,
   output logic [2:0] s,
   output logic       y,
   output logic       y_valid,
   output logic       busy
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] ptr_q, ptr_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] gnt_q, gnt_d;
   logic [2:0] s_q, s_d;
   logic       y_q, y_d;
   logic       y_valid_q, y_valid_d;

   logic [3:0] pick;         // {found, index}
   logic       release_c;

   // Returns {found, index} of the first set bit of r, searching upward from
   // start and wrapping 7 -> 0. The loop runs from the farthest offset to the
   // nearest so that the nearest hit is the last assignment.
   function automatic logic [3:0] rr_pick(input logic [2:0] start,
                                          input logic [7:0] r);
      logic [3:0] res;
      logic [2:0] idx;
      res = 4'b0;
      for (int i = 7; i >= 0; i--) begin
         idx = start + 3'(i);
         if (r[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      gnt_d     = gnt_q;
      s_d       = s_q;
      pick      = 4'b0;
      release_c = 1'b0;

      case (state_q)
         ST_IDLE: begin
            pick = rr_pick(ptr_q, req);
            if (pick[3]) begin
               gnt_d   = 8'b1 << pick[2:0];
               s_d     = pick[2:0];
               cnt_d   = 4'd1;
               state_d = ST_GRANT;
            end
         end
         ST_GRANT: begin
            release_c = !req[s_q] || (cnt_q == 4'(MAX_HOLD));
            if (!release_c) begin
               cnt_d = cnt_q + 4'd1;
            end else begin
               // Priority moves past the releasing requester; the same
               // requester can still win again if nobody else is asking.
               ptr_d = s_q + 3'd1;
               pick  = rr_pick(s_q + 3'd1, req);
               if (pick[3]) begin
                  gnt_d = 8'b1 << pick[2:0];
                  s_d   = pick[2:0];
                  cnt_d = 4'd1;
               end else begin
                  gnt_d   = 8'b0;
                  cnt_d   = 4'd0;
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = 8'b0;
         end
      endcase

      // Sample only while the granted requester is still asserting req.
      y_valid_d = (state_q == ST_GRANT) && req[s_q];
      y_d       = y_valid_d ? din[s_q] : y_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         ptr_q     <= 3'd0;
         cnt_q     <= 4'd0;
         gnt_q     <= 8'd0;
         s_q       <= 3'd0;
         y_q       <= 1'b0;
         y_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         gnt_q     <= gnt_d;
         s_q       <= s_d;
         y_q       <= y_d;
         y_valid_q <= y_valid_d;
      end
   end

   assign gnt     = gnt_q;
   assign s       = s_q;
   assign y       = y_q;
   assign y_valid = y_valid_q;
   assign busy    = (state_q == ST_GRANT);

endmodule
